// File: rtl/ppu_pkg.sv
// Shared definitions for the pixel pattern unit: pattern modes, default
// geometry and the small helpers used by the pattern generator.
package ppu_pkg;

    localparam int NREGS_DEF   = 10;
    localparam int H_TOTAL_DEF = 800;
    localparam int V_TOTAL_DEF = 525;
    localparam int CRD_W       = 16;

    typedef enum logic [2:0] {
        MODE_SOLID   = 3'd0,
        MODE_HBARS   = 3'd1,
        MODE_VBARS   = 3'd2,
        MODE_CHECKER = 3'd3,
        MODE_XOR     = 3'd4,
        MODE_PLASMA  = 3'd5,
        MODE_GRID    = 3'd6,
        MODE_DIAG    = 3'd7
    } mode_e;

    // Saturate a bar index so the last register covers the remainder of the screen.
    function automatic logic [CRD_W-1:0] clamp_idx(input logic [CRD_W-1:0] v,
                                                   input logic [CRD_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/ppu_pattern_gen.sv
// Combinational pattern generator: maps mode, pixel coordinates, frame
// number and the pattern registers onto one RRGGBBxx pixel byte.
module ppu_pattern_gen
    import ppu_pkg::*;
#(
    parameter int NREGS = NREGS_DEF
) (
    input  mode_e                  mode,
    input  logic [CRD_W-1:0]       x,
    input  logic [CRD_W-1:0]       y,
    input  logic [7:0]             frame,
    input  logic [NREGS-1:0][7:0]  regs,
    output logic [7:0]             pixel
);

    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [CRD_W-1:0] IDX_LAST = CRD_W'(NREGS - 1);

    logic [CRD_W-1:0] hbar_s;
    logic [CRD_W-1:0] vbar_s;
    logic [CRD_W-1:0] diff_s;
    logic [7:0]       sum_s;
    logic [IW-1:0]    hidx_s;
    logic [IW-1:0]    vidx_s;

    assign hbar_s = clamp_idx(x >> 6, IDX_LAST);
    assign vbar_s = clamp_idx(y >> 5, IDX_LAST);
    assign hidx_s = hbar_s[IW-1:0];
    assign vidx_s = vbar_s[IW-1:0];
    assign diff_s = x - y;
    assign sum_s  = x[7:0] + y[7:0] + frame;

    // Select the pixel byte for the requested pattern.
    always_comb begin
        pixel = 8'h00;
        case (mode)
            MODE_SOLID:   pixel = regs[0];
            MODE_HBARS:   pixel = regs[hidx_s];
            MODE_VBARS:   pixel = regs[vidx_s];
            MODE_CHECKER: pixel = (x[5] ^ y[5]) ? regs[1] : regs[2];
            MODE_XOR:     pixel = x[7:0] ^ y[7:0] ^ regs[3];
            MODE_PLASMA:  pixel = sum_s ^ regs[4];
            MODE_GRID:    pixel = regs[5] & {x[8:6], y[8:6], 2'b00};
            MODE_DIAG:    pixel = (diff_s[3:0] == 4'd0) ? regs[6] : regs[7];
            default:      pixel = 8'h00;
        endcase
    end

endmodule

// File: rtl/ppu.sv
// Pixel pattern unit: loads pattern registers during the sync phase and
// streams one pixel byte per accepted handshake during the run phase.
module ppu
    import ppu_pkg::*;
#(
    parameter int NREGS   = NREGS_DEF,
    parameter int H_TOTAL = H_TOTAL_DEF,
    parameter int V_TOTAL = V_TOTAL_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sync,
    input  logic [2:0] mode,
    input  logic [7:0] data_i,
    input  logic       stb_i,
    output logic       ack_i,
    output logic [7:0] data_o,
    output logic       stb_o,
    input  logic       ack_o
);

    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [IW-1:0]    WPTR_LAST = IW'(NREGS - 1);
    localparam logic [CRD_W-1:0] X_LAST    = CRD_W'(H_TOTAL - 1);
    localparam logic [CRD_W-1:0] Y_LAST    = CRD_W'(V_TOTAL - 1);

    logic [NREGS-1:0][7:0] regs_r;
    logic [IW-1:0]         wptr_r;
    logic [CRD_W-1:0]      x_r;
    logic [CRD_W-1:0]      y_r;
    logic [7:0]            frame_r;
    logic [7:0]            data_o_r;
    logic                  stb_o_r;

    logic [CRD_W-1:0]      nx_s;
    logic [CRD_W-1:0]      ny_s;
    logic [7:0]            nf_s;
    logic [CRD_W-1:0]      gx_s;
    logic [CRD_W-1:0]      gy_s;
    logic [7:0]            gf_s;
    logic [7:0]            pixel_s;
    logic                  accept_s;

    assign ack_i    = rst & sync & stb_i;
    assign accept_s = stb_o_r & ack_o;
    assign data_o   = data_o_r;
    assign stb_o    = stb_o_r;

    // Raster position that follows the pixel currently on data_o.
    always_comb begin
        nx_s = x_r + 16'd1;
        ny_s = y_r;
        nf_s = frame_r;
        if (x_r == X_LAST) begin
            nx_s = '0;
            if (y_r == Y_LAST) begin
                ny_s = '0;
                nf_s = frame_r + 8'd1;
            end else begin
                ny_s = y_r + 16'd1;
            end
        end else begin
            nx_s = x_r + 16'd1;
        end
    end

    // The first run cycle renders the current (origin) position; afterwards
    // each acceptance renders the following position.
    assign gx_s = stb_o_r ? nx_s : x_r;
    assign gy_s = stb_o_r ? ny_s : y_r;
    assign gf_s = stb_o_r ? nf_s : frame_r;

    ppu_pattern_gen #(
        .NREGS (NREGS)
    ) u_pattern_gen (
        .mode  (mode_e'(mode)),
        .x     (gx_s),
        .y     (gy_s),
        .frame (gf_s),
        .regs  (regs_r),
        .pixel (pixel_s)
    );

    // Pattern register file and its write pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_r <= '0;
            wptr_r <= '0;
        end else if (sync) begin
            if (stb_i) begin
                regs_r[wptr_r] <= data_i;
                wptr_r         <= (wptr_r == WPTR_LAST) ? '0 : wptr_r + 1'b1;
            end
        end else begin
            wptr_r <= '0;
        end
    end

    // Raster counters, advanced only by accepted pixels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_r     <= '0;
            y_r     <= '0;
            frame_r <= 8'd0;
        end else if (sync) begin
            x_r     <= '0;
            y_r     <= '0;
            frame_r <= 8'd0;
        end else if (accept_s) begin
            x_r     <= nx_s;
            y_r     <= ny_s;
            frame_r <= nf_s;
        end
    end

    // Output pixel register and its strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_o_r <= 8'd0;
            stb_o_r  <= 1'b0;
        end else if (sync) begin
            data_o_r <= 8'd0;
            stb_o_r  <= 1'b0;
        end else begin
            stb_o_r <= 1'b1;
            if (!stb_o_r || ack_o) begin
                data_o_r <= pixel_s;
            end
        end
    end

endmodule

// File: tb/tb_ppu.sv
// Randomised scoreboard bench for ppu: the stimulus side predicts each
// rendered pixel from a linear pixel index; a monitor checks what appears.
module tb_ppu;

    localparam int NR    = 10;
    localparam int H     = 800;
    localparam int V     = 34;
    localparam int FRAME = H * V;

    logic       clk = 1'b0;
    logic       rst;
    logic       sync;
    logic [2:0] mode;
    logic [7:0] data_i;
    logic       stb_i;
    logic       ack_i;
    logic [7:0] data_o;
    logic       stb_o;
    logic       ack_o;

    always #5 clk = ~clk;

    ppu #(.NREGS(NR), .H_TOTAL(H), .V_TOTAL(V)) dut (
        .clk    (clk),
        .rst    (rst),
        .sync   (sync),
        .mode   (mode),
        .data_i (data_i),
        .stb_i  (stb_i),
        .ack_i  (ack_i),
        .data_o (data_o),
        .stb_o  (stb_o),
        .ack_o  (ack_o)
    );

    int         vecs = 0;
    int         errs = 0;
    logic [7:0] mreg [NR];
    int         wcnt;
    int         pix_n;
    bit         stb_model;
    logic [7:0] sb_q [$];

    logic [7:0] spec_bytes [NR] = '{8'd42, 8'd123, 8'd87, 8'd255, 8'd0,
                                    8'd198, 8'd76, 8'd34, 8'd210, 8'hB6};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference pixel n of the raster stream (n counts from the first pixel of a run).
    function automatic logic [7:0] ref_pixel(input int n, input int m);
        int x;
        int y;
        int f;
        int idx;
        x = n % H;
        y = (n / H) % V;
        f = (n / FRAME) % 256;
        case (m)
            0: return mreg[0];
            1: begin idx = x / 64; if (idx > NR - 1) idx = NR - 1; return mreg[idx]; end
            2: begin idx = y / 32; if (idx > NR - 1) idx = NR - 1; return mreg[idx]; end
            3: return (((x / 32) % 2) != ((y / 32) % 2)) ? mreg[1] : mreg[2];
            4: return 8'((x % 256) ^ (y % 256)) ^ mreg[3];
            5: return 8'((x + y + f) % 256) ^ mreg[4];
            6: return mreg[5] & 8'((((x / 64) % 8) << 5) | (((y / 64) % 8) << 2));
            7: return ((((x - y) % 16) + 16) % 16 == 0) ? mreg[6] : mreg[7];
            default: return 8'h00;
        endcase
    endfunction

    // One clock of stimulus; predicts what the coming edge renders.
    task automatic cyc(input bit s, input bit si, input logic [7:0] d, input int m, input bit a);
        @(posedge clk);
        #1;
        sync   = s;
        stb_i  = si;
        data_i = d;
        mode   = 3'(m);
        ack_o  = a;
        if (s) begin
            if (si) begin
                mreg[wcnt] = d;
                wcnt = (wcnt + 1) % NR;
            end
        end else begin
            wcnt = 0;
            if (!stb_model) begin
                pix_n = 0;
                sb_q.push_back(ref_pixel(0, m));
            end else if (a) begin
                pix_n++;
                sb_q.push_back(ref_pixel(pix_n, m));
            end
        end
        stb_model = !s;
    endtask

    task automatic load_spec(input int nbytes, input logic [7:0] extra);
        for (int i = 0; i < nbytes; i++) begin
            cyc(1'b1, 1'b1, (i < NR) ? spec_bytes[i] : extra, 0, 1'b0);
        end
    endtask

    task automatic run(input int n, input int m, input bit a);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, m, a);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) mreg[i] = 8'h00;
        wcnt = 0;
        pix_n = 0;
        stb_model = 1'b0;
        sb_q.delete();
    endtask

    // Mid-run asynchronous reset followed by a clean release.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_stb_o", stb_o, 1'b0);
        check("async_rst_data_o", data_o, 8'h00);
        sync = 1'b1;
        stb_i = 1'b1;
        #1;
        check("rst_ack_i", ack_i, 1'b0);
        model_clear();
        stb_i = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    // Monitor: checks handshake outputs every cycle and pops one expected
    // pixel whenever a new pixel is presented.
    bit         have_prev = 1'b0;
    bit         prev_sync = 1'b1;
    bit         prev_stb  = 1'b0;
    bit         prev_acc  = 1'b0;
    logic [7:0] held = 8'h00;

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            have_prev = 1'b0;
            prev_stb  = 1'b0;
            prev_acc  = 1'b0;
        end else begin
            check("ack_i", ack_i, sync & stb_i);
            check("stb_o", stb_o, have_prev && !prev_sync);
            if (stb_o === 1'b1) begin
                if (!prev_stb || prev_acc) begin
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", 32'd0, 32'd1);
                    end else begin
                        held = sb_q.pop_front();
                        check("pixel", data_o, held);
                    end
                end else begin
                    check("pixel_hold", data_o, held);
                end
            end else begin
                check("idle_data_o", data_o, 8'h00);
            end
            prev_sync = sync;
            prev_stb  = (stb_o === 1'b1);
            prev_acc  = (stb_o === 1'b1) && (ack_o === 1'b1);
            have_prev = 1'b1;
        end
    end

    initial begin
        int m;
        rst    = 1'b0;
        sync   = 1'b1;
        stb_i  = 1'b0;
        data_i = 8'h00;
        mode   = 3'd0;
        ack_o  = 1'b0;
        model_clear();
        #1;
        check("reset_stb_o", stb_o, 1'b0);
        check("reset_data_o", data_o, 8'h00);
        check("reset_ack_i", ack_i, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;

        // Spec load, solid colour, then stall mid-line.
        load_spec(NR, 8'h00);
        run(20, 0, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 0, 1'b0);
        run(10, 4, 1'b1);
        run(5, 4, 1'b0);
        run(10, 7, 1'b1);

        // A full frame plus margin with mode changes and random back-pressure.
        cyc(1'b1, 1'b0, 8'h00, 0, 1'b0);
        for (int i = 0; i < FRAME * 8 / 7 + 600; i++) begin
            if (pix_n + 1 >= FRAME - 10 && pix_n + 1 <= FRAME + 40) m = 5;
            else if (pix_n + 1 >= 25600 && pix_n + 1 <= 25700) m = 3;
            else m = (pix_n / 97) % 8;
            cyc(1'b0, 1'b0, 8'h00, m, $urandom_range(0, 7) != 0);
        end

        // Eleven-byte load wraps onto reg[0].
        cyc(1'b1, 1'b0, 8'h00, 0, 1'b0);
        load_spec(NR + 1, 8'h55);
        run(10, 0, 1'b1);
        run(5, 1, 1'b1);

        // Random loads and runs, including sync rising mid-run.
        for (int seg = 0; seg < 40; seg++) begin
            int nload;
            int nrun;
            nload = $urandom_range(1, 13);
            for (int i = 0; i < nload; i++) begin
                cyc(1'b1, $urandom_range(0, 3) != 0, 8'($urandom), 0, $urandom_range(0, 1));
            end
            nrun = $urandom_range(20, 120);
            m = $urandom_range(0, 7);
            for (int i = 0; i < nrun; i++) begin
                if ($urandom_range(0, 9) == 0) m = $urandom_range(0, 7);
                cyc(1'b0, 1'b0, 8'($urandom), m, $urandom_range(0, 1));
            end
        end

        // Reset mid-run, then a fresh load.
        cyc(1'b1, 1'b0, 8'h00, 0, 1'b0);
        load_spec(NR, 8'h00);
        run(10, 0, 1'b1);
        do_reset();
        run(5, 0, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 0, 1'b0);
        cyc(1'b1, 1'b1, 8'hA5, 0, 1'b0);
        cyc(1'b1, 1'b1, 8'h3C, 0, 1'b0);
        run(10, 0, 1'b1);
        run(10, 1, 1'b1);

        repeat (3) cyc(1'b1, 1'b0, 8'h00, 0, 1'b0);
        @(posedge clk);
        #1;
        check("sb_drained", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
